// File: rtl/dram_ctrl_if.sv
// Request/response channel between a requester and dram_ctrl.
// master = requester side, slave = controller side.
interface dram_ctrl_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_perr;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_perr
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_perr
    );
endinterface

// File: rtl/dram_ctrl.sv
// Single-request DRAM controller: one outstanding write or read at a time.
// Define DRAM_CTRL_PARITY_EN to store/check per-byte even parity in bits DATA_W+7:DATA_W.
module dram_ctrl #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    dram_ctrl_if.slave        bus,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W+7:0] mem_dataIN,
    output logic              mem_Write_ReadCOMP,
    input  logic [DATA_W+7:0] mem_dataOUT
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RDCAP,
        RESP
    } state_t;

    state_t            state;
    logic              ready_q;
    logic              valid_q;
    logic [DATA_W-1:0] rdata_q;
    logic              perr_q;
    logic [DATA_W+7:0] wr_word;
    logic              rd_err;

`ifdef DRAM_CTRL_PARITY_EN
    function automatic logic [7:0] par(input logic [DATA_W-1:0] d);
        logic [7:0] p;
        for (int k = 0; k < 8; k++) p[k] = ^d[8*k +: 8];
        return p;
    endfunction

    assign wr_word = {par(bus.req_wdata), bus.req_wdata};
    assign rd_err  = |(par(mem_dataOUT[DATA_W-1:0])
                     ^ mem_dataOUT[DATA_W+7:DATA_W]);
`else
    logic unused_par;

    assign wr_word    = {8'h00, bus.req_wdata};
    assign rd_err     = 1'b0;
    assign unused_par = ^mem_dataOUT[DATA_W+7:DATA_W];
`endif

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_perr  = perr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            ready_q            <= 1'b1;
            valid_q            <= 1'b0;
            rdata_q            <= '0;
            perr_q             <= 1'b0;
            mem_Write_ReadCOMP <= 1'b0;
            mem_address        <= '0;
            mem_dataIN         <= '0;
        end else begin
            mem_Write_ReadCOMP <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.req_valid && ready_q) begin
                        ready_q     <= 1'b0;
                        mem_address <= bus.req_addr;
                        if (bus.req_we) begin
                            mem_dataIN         <= wr_word;
                            mem_Write_ReadCOMP <= 1'b1;
                            state              <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                WRITE: begin
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                READ: state <= RDCAP;
                RDCAP: begin
                    rdata_q <= mem_dataOUT[DATA_W-1:0];
                    perr_q  <= rd_err;
                    state   <= RESP;
                end
                RESP: begin
                    // data settles one cycle before valid is raised
                    if (valid_q && bus.rsp_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        valid_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dram_ctrl.md
DRAM_CTRL -- requirements
Module: dram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 2, DRAM word address width (4 words).
REQ-002 SHALL have parameter DATA_W, default 64, payload width; DRAM word width is DATA_W+8 (72).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  controller can accept a request this cycle.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  ADDR_W  target word address.
REQ-009 req_wdata  input  DATA_W  write payload.
REQ-010 rsp_valid  output  1  read response held valid.
REQ-011 rsp_ready  input  1  consumer accepts the response.
REQ-012 rsp_rdata  output  DATA_W  read payload.
REQ-013 rsp_perr  output  1  parity error on the returned word.
REQ-014 mem_address  output  ADDR_W  address to DRAM.
REQ-015 mem_dataIN  output  DATA_W+8  write word to DRAM.
REQ-016 mem_Write_ReadCOMP  output  1  1 = DRAM write, 0 = DRAM read.
REQ-017 mem_dataOUT  input  DATA_W+8  DRAM read word, registered by DRAM one edge after address is presented with mem_Write_ReadCOMP=0.

Function
REQ-018 SHALL implement FSM states IDLE, WRITE, READ, RDCAP, RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; acceptance = req_valid & req_ready at a rising edge.
REQ-020 On acceptance, SHALL latch req_addr, req_we, req_wdata; next state WRITE if req_we=1, else READ.
REQ-021 WRITE: drive mem_Write_ReadCOMP=1, mem_address=latched address, mem_dataIN=encoded latched data for exactly one cycle; next state IDLE; no response generated.
REQ-022 READ: drive mem_Write_ReadCOMP=0, mem_address=latched address; next state RDCAP.
REQ-023 RDCAP: capture mem_dataOUT[DATA_W-1:0] into rsp_rdata and computed parity result into rsp_perr; next state RESP.
REQ-024 RESP: rsp_valid=1; rsp_rdata/rsp_perr held stable; on rsp_valid & rsp_ready move to IDLE.
REQ-025 Read latency: rsp_valid SHALL be 1 from the 3rd rising edge after the accepting edge (accept edge counted as 0, rsp_valid first seen after edge 3); write occupancy 1 cycle, so back-to-back writes accept every 2 cycles.
REQ-026 Outside WRITE, mem_Write_ReadCOMP SHALL be 0 (no spurious DRAM writes); mem_address SHALL hold the last latched address.
REQ-027 Requests arriving while req_ready=0 SHALL be ignored (requester holds them).
REQ-028 rsp_valid SHALL never assert for a write.

Reset
REQ-029 reset=0 SHALL immediately force state IDLE, req_ready=1 after release, rsp_valid=0, rsp_rdata=0, rsp_perr=0, mem_Write_ReadCOMP=0, mem_address=0, mem_dataIN=0.
REQ-030 Reset during WRITE SHALL drop mem_Write_ReadCOMP to 0 asynchronously; reset during READ/RDCAP/RESP SHALL discard the pending response.

Configuration
REQ-031 Macro DRAM_CTRL_PARITY_EN defined: mem_dataIN[DATA_W+k] = XOR of req_wdata byte k (k=0..7, even parity); on read, rsp_perr=1 if any byte's stored parity bit differs from XOR of returned byte.
REQ-032 Macro undefined: mem_dataIN[DATA_W+7:DATA_W]=0, mem_dataOUT upper 8 bits ignored, rsp_perr constant 0.

Verification
REQ-033 Reset, write addr 1 data 64'h0123_4567_89AB_CDEF, read addr 1 -> rsp_rdata=64'h0123_4567_89AB_CDEF, rsp_perr=0, rsp_valid first high 3 edges after read acceptance.
REQ-034 Write to all 4 addresses (data 64'h11..,22..,33..,44..), read in order 3,2,1,0 -> data 44..,33..,22..,11.., each write shows mem_Write_ReadCOMP=1 for exactly one cycle.
REQ-035 Read with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; rsp_ready=1 -> IDLE next edge.
REQ-036 PARITY_EN defined: write 64'hFF, model flips DRAM bit 64 -> read returns rsp_perr=1; undefined: mem_dataIN[71:64]=8'h00, rsp_perr=0.
REQ-037 Assert reset=0 mid-WRITE (between edges) -> mem_Write_ReadCOMP=0 immediately, rsp_valid=0, req_ready=1 after release.
REQ-038 req_valid held high with alternating writes/reads -> acceptance only in IDLE, no accepted request lost or duplicated.
